// File: rtl/id_stage_pkg.sv
// Shared decode constants for the LEGv8 instruction-decode stage.
// Opcode match patterns, ALU control codes and the zero-register index.
package id_stage_pkg;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [3:0] {
    I_NOP, I_LDUR, I_STUR, I_ADD, I_SUB, I_AND, I_ORR, I_CBZ, I_B, I_MOVZ
  } instr_e;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       uncondbranch;
    logic [3:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/id_stage_regfile.sv
// 31 x XLEN register file with XZR at index 31, two async read ports,
// one write port on posedge and write-through bypass to both read ports.
module id_stage_regfile
  import id_stage_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 64
) (
  input  logic            CLK,
  input  logic            resetl,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] r_regs [NREGS-1];
  logic            w_wr_ok;

  assign w_wr_ok = i_we && (i_wa != XZR);

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      for (int i = 0; i < NREGS-1; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  always_comb begin
    o_rd1 = '0;
    if (i_ra1 == XZR)                  o_rd1 = '0;
    else if (w_wr_ok && i_wa == i_ra1) o_rd1 = i_wd;
    else                               o_rd1 = r_regs[i_ra1];
  end

  always_comb begin
    o_rd2 = '0;
    if (i_ra2 == XZR)                  o_rd2 = '0;
    else if (w_wr_ok && i_wa == i_ra2) o_rd2 = i_wd;
    else                               o_rd2 = r_regs[i_ra2];
  end

endmodule

// File: rtl/id_stage.sv
// LEGv8 instruction-decode stage: control decode, immediate extension,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 64
) (
  input  logic            CLK,
  input  logic            resetl,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_nextseqpc,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rdata1,
  output logic [XLEN-1:0] ex_rdata2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_aluop,
  output logic            ex_alusrc,
  output logic            ex_memtoreg,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_branch,
  output logic            ex_uncondbranch
);

  instr_e          w_cls;
  ctrl_t           w_ctrl;
  ctrl_t           r_ctrl;
  logic [XLEN-1:0] w_imm;
  logic [4:0]      w_rs1, w_rs2;
  logic            w_rs1_used, w_rs2_used;
  logic [XLEN-1:0] w_rdata1, w_rdata2;

  always_comb begin
    w_cls = I_NOP;
    unique case (id_instr[31:21])
      OP_LDUR: w_cls = I_LDUR;
      OP_STUR: w_cls = I_STUR;
      OP_ADD:  w_cls = I_ADD;
      OP_SUB:  w_cls = I_SUB;
      OP_AND:  w_cls = I_AND;
      OP_ORR:  w_cls = I_ORR;
      default: begin
        if (id_instr[31:24] == OP_CBZ)       w_cls = I_CBZ;
        else if (id_instr[31:26] == OP_B)    w_cls = I_B;
        else if (id_instr[31:23] == OP_MOVZ) w_cls = I_MOVZ;
      end
    endcase
  end

  // Control bits: {alusrc, memtoreg, regwrite, memread, memwrite, branch, uncond, aluop}
  always_comb begin
    w_ctrl = '0;
    w_imm  = '0;
    case (w_cls)
      I_LDUR: begin
        w_ctrl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD};
        w_imm  = {{55{id_instr[20]}}, id_instr[20:12]};
      end
      I_STUR: begin
        w_ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_ADD};
        w_imm  = {{55{id_instr[20]}}, id_instr[20:12]};
      end
      I_ADD:  w_ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD};
      I_SUB:  w_ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB};
      I_AND:  w_ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_AND};
      I_ORR:  w_ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ORR};
      I_CBZ: begin
        w_ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_PASSB};
        w_imm  = {{43{id_instr[23]}}, id_instr[23:5], 2'b00};
      end
      I_B: begin
        w_ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_AND};
        w_imm  = {{36{id_instr[25]}}, id_instr[25:0], 2'b00};
      end
      I_MOVZ: begin
        w_ctrl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_PASSB};
        w_imm  = {48'd0, id_instr[20:5]} << {id_instr[22:21], 4'b0000};
      end
      default: ;
    endcase
  end

  assign w_rs1      = id_instr[9:5];
  assign w_rs2      = (w_cls == I_STUR || w_cls == I_CBZ) ? id_instr[4:0] : id_instr[20:16];
  assign w_rs1_used = !(w_cls == I_B || w_cls == I_MOVZ);
  assign w_rs2_used = (w_cls inside {I_ADD, I_SUB, I_AND, I_ORR, I_STUR, I_CBZ});

  assign stall = r_ctrl.memread && (ex_rd != XZR) &&
                 ((ex_rd == w_rs1 && w_rs1_used) || (ex_rd == w_rs2 && w_rs2_used));

  id_stage_regfile #(.NREGS(NREGS), .XLEN(XLEN)) u_regfile (
    .CLK    (CLK),
    .resetl (resetl),
    .i_ra1  (w_rs1),
    .i_ra2  (w_rs2),
    .i_we   (wb_regwrite),
    .i_wa   (wb_rd),
    .i_wd   (wb_data),
    .o_rd1  (w_rdata1),
    .o_rd2  (w_rdata2)
  );

  // A bubble clears the data fields too so EX never sees stale operands.
  always_ff @(posedge CLK) begin
    if (!resetl || flush || stall) begin
      r_ctrl    <= '0;
      ex_pc     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_rd     <= '0;
    end else begin
      r_ctrl    <= w_ctrl;
      ex_pc     <= id_nextseqpc - 64'd4;
      ex_rdata1 <= w_rdata1;
      ex_rdata2 <= w_rdata2;
      ex_imm    <= w_imm;
      ex_rd     <= id_instr[4:0];
    end
  end

  assign ex_aluop        = r_ctrl.aluop;
  assign ex_alusrc       = r_ctrl.alusrc;
  assign ex_memtoreg     = r_ctrl.memtoreg;
  assign ex_regwrite     = r_ctrl.regwrite;
  assign ex_memread      = r_ctrl.memread;
  assign ex_memwrite     = r_ctrl.memwrite;
  assign ex_branch       = r_ctrl.branch;
  assign ex_uncondbranch = r_ctrl.uncondbranch;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed test-plan sequence then random
// instruction/writeback traffic checked against an instruction-level model.
module tb_id_stage;

  logic        CLK = 1'b0;
  logic        resetl;
  logic [31:0] id_instr;
  logic [63:0] id_nextseqpc;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush;
  logic        stall;
  logic [63:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_aluop;
  logic        ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread;
  logic        ex_memwrite, ex_branch, ex_uncondbranch;

  id_stage dut (
    .CLK(CLK), .resetl(resetl), .id_instr(id_instr), .id_nextseqpc(id_nextseqpc),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .stall(stall), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_uncondbranch(ex_uncondbranch)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] pc, r1, r2, imm;
    logic [4:0]  rd;
    logic [3:0]  aluop;
    logic [6:0]  ctl;  // alusrc,memtoreg,regwrite,memread,memwrite,branch,uncond
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;

  logic [63:0] mregs [32];
  bit          m_valid = 0;
  bit          m_ex_memread = 0;
  logic [4:0]  m_ex_rd = 0;

  function automatic logic [31:0] enc_r(logic [10:0] op, logic [4:0] rm, logic [4:0] rn, logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(logic [10:0] op, logic [8:0] imm, logic [4:0] rn, logic [4:0] rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_b(logic [25:0] imm);
    return {6'b000101, imm};
  endfunction
  function automatic logic [31:0] enc_cb(logic [18:0] imm, logic [4:0] rt);
    return {8'b10110100, imm, rt};
  endfunction
  function automatic logic [31:0] enc_movz(logic [1:0] hw, logic [15:0] imm, logic [4:0] rd);
    return {9'b110100101, hw, imm, rd};
  endfunction

  // 0 NOP, 1 LDUR, 2 STUR, 3 ADD, 4 SUB, 5 AND, 6 ORR, 7 CBZ, 8 B, 9 MOVZ
  function automatic int classify(logic [31:0] ins);
    logic [10:0] o;
    o = ins[31:21];
    if (o == 11'b11111000010) return 1;
    if (o == 11'b11111000000) return 2;
    if (o == 11'b10001011000) return 3;
    if (o == 11'b11001011000) return 4;
    if (o == 11'b10001010000) return 5;
    if (o == 11'b10101010000) return 6;
    if (ins[31:24] == 8'b10110100) return 7;
    if (ins[31:26] == 6'b000101) return 8;
    if (ins[31:23] == 9'b110100101) return 9;
    return 0;
  endfunction

  function automatic logic [63:0] model_imm(int c, logic [31:0] ins);
    longint v;
    v = 0;
    case (c)
      1, 2: begin v = longint'(ins[20:12]); if (v >= 256) v -= 512; end
      7: begin v = longint'(ins[23:5]); if (v >= (1 << 18)) v -= (1 << 19); v = v * 4; end
      8: begin v = longint'(ins[25:0]); if (v >= (1 << 25)) v -= (1 << 26); v = v * 4; end
      9: v = longint'(ins[20:5]) << (16 * int'(ins[22:21]));
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [63:0] npc, input bit wbe,
                       input logic [4:0] wrd, input logic [63:0] wd, input bit fl,
                       input bit rst, output bit stl);
    int          c;
    logic [4:0]  rs1, rs2;
    bit          u1, u2, es;
    exp_t        e;
    logic [63:0] v1, v2;
    @(negedge CLK);
    resetl = !rst; id_instr = ins; id_nextseqpc = npc;
    wb_regwrite = wbe; wb_rd = wrd; wb_data = wd; flush = fl;
    #1;
    c   = classify(ins);
    rs1 = ins[9:5];
    rs2 = (c == 2 || c == 7) ? ins[4:0] : ins[20:16];
    u1  = !(c == 8 || c == 9);
    u2  = (c >= 2 && c <= 7);
    es  = m_valid && m_ex_memread && m_ex_rd != 5'd31 &&
          ((m_ex_rd == rs1 && u1) || (m_ex_rd == rs2 && u2));
    if (m_valid) chk("stall", 64'(stall), 64'(es));
    v1 = (rs1 == 5'd31) ? 64'd0 : (wbe && wrd == rs1) ? wd : mregs[rs1];
    v2 = (rs2 == 5'd31) ? 64'd0 : (wbe && wrd == rs2) ? wd : mregs[rs2];
    e = '0;
    if (!rst && !fl && !es) begin
      e.pc = npc - 64'd4; e.r1 = v1; e.r2 = v2; e.rd = ins[4:0];
      e.imm = model_imm(c, ins);
      case (c)
        1: begin e.ctl = 7'b1111000; e.aluop = 4'b0010; end
        2: begin e.ctl = 7'b1000100; e.aluop = 4'b0010; end
        3: begin e.ctl = 7'b0010000; e.aluop = 4'b0010; end
        4: begin e.ctl = 7'b0010000; e.aluop = 4'b0110; end
        5: begin e.ctl = 7'b0010000; e.aluop = 4'b0000; end
        6: begin e.ctl = 7'b0010000; e.aluop = 4'b0001; end
        7: begin e.ctl = 7'b0000010; e.aluop = 4'b0111; end
        8: begin e.ctl = 7'b0000001; e.aluop = 4'b0000; end
        9: begin e.ctl = 7'b1010000; e.aluop = 4'b0111; end
        default: begin e.ctl = '0; e.aluop = '0; end
      endcase
    end
    sb.push_back(e);
    m_valid = 1; m_ex_memread = e.ctl[3]; m_ex_rd = e.rd;
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = '0;
    end else if (wbe && wrd != 5'd31) begin
      mregs[wrd] = wd;
    end
    stl = es;
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ex_pc", ex_pc, e.pc);
      chk("ex_rdata1", ex_rdata1, e.r1);
      chk("ex_rdata2", ex_rdata2, e.r2);
      chk("ex_imm", ex_imm, e.imm);
      chk("ex_rd", 64'(ex_rd), 64'(e.rd));
      chk("ex_aluop", 64'(ex_aluop), 64'(e.aluop));
      chk("ex_ctl", 64'({ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                         ex_memwrite, ex_branch, ex_uncondbranch}), 64'(e.ctl));
    end
  end

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 9))
      0: return $urandom;
      1: return enc_d(11'b11111000010, 9'($urandom), pick_reg(), pick_reg());
      2: return enc_d(11'b11111000000, 9'($urandom), pick_reg(), pick_reg());
      3: return enc_r(11'b10001011000, pick_reg(), pick_reg(), pick_reg());
      4: return enc_r(11'b11001011000, pick_reg(), pick_reg(), pick_reg());
      5: return enc_r(11'b10001010000, pick_reg(), pick_reg(), pick_reg());
      6: return enc_r(11'b10101010000, pick_reg(), pick_reg(), pick_reg());
      7: return enc_cb(19'($urandom), pick_reg());
      8: return enc_b(26'($urandom));
      default: return enc_movz(2'($urandom), 16'($urandom), pick_reg());
    endcase
  endfunction

  initial begin
    bit          s;
    logic [31:0] ins;
    logic [63:0] pc;
    bit          retry;
    bit          fl;
    resetl = 0; id_instr = 0; id_nextseqpc = 0;
    wb_regwrite = 0; wb_rd = 0; wb_data = 0; flush = 0;
    pc = 64'h1000;
    drive(32'h8B1F03E1, 64'h4, 0, 0, 0, 0, 1, s);
    drive(32'h8B1F03E1, 64'h4, 0, 0, 0, 0, 1, s);
    // X31 write ignored; reading X31 gives 0
    drive(32'h8B1F03E1, 64'h104, 1, 5'd31, 64'hDEAD, 0, 0, s);
    drive(32'h8B1F03E1, 64'h108, 0, 0, 0, 0, 0, s);
    // bypass of X2
    drive(enc_r(11'b11001011000, 5'd2, 5'd2, 5'd3), 64'h10C, 1, 5'd2, 64'h1234, 0, 0, s);
    // load-use: stall then retry
    drive(enc_d(11'b11111000010, 9'h1F8, 5'd0, 5'd5), 64'h110, 0, 0, 0, 0, 0, s);
    drive(enc_r(11'b10001011000, 5'd1, 5'd5, 5'd6), 64'h114, 0, 0, 0, 0, 0, s);
    drive(enc_r(11'b10001011000, 5'd1, 5'd5, 5'd6), 64'h114, 1, 5'd5, 64'h55, 0, 0, s);
    // no hazard on XZR or on MOVZ's unused rs1
    drive(enc_d(11'b11111000010, 9'h010, 5'd0, 5'd31), 64'h118, 0, 0, 0, 0, 0, s);
    drive(enc_r(11'b10001011000, 5'd2, 5'd31, 5'd1), 64'h11C, 0, 0, 0, 0, 0, s);
    drive(enc_d(11'b11111000010, 9'h000, 5'd0, 5'd4), 64'h120, 0, 0, 0, 0, 0, s);
    drive(enc_movz(2'd1, 16'd1, 5'd4), 64'h124, 0, 0, 0, 0, 0, s);
    // branch immediates and flush
    drive(enc_b(26'h3FFFFFF), 64'h128, 0, 0, 0, 0, 0, s);
    drive(enc_cb(19'd3, 5'd3), 64'h12C, 0, 0, 0, 0, 0, s);
    drive(enc_r(11'b10001011000, 5'd2, 5'd3, 5'd7), 64'h130, 0, 0, 0, 1, 0, s);
    drive(enc_d(11'b11111000010, 9'h004, 5'd2, 5'd6), 64'h134, 0, 0, 0, 0, 0, s);
    drive(enc_d(11'b11111000000, 9'h004, 5'd2, 5'd6), 64'h138, 0, 0, 0, 1, 0, s);

    retry = 0; ins = 0;
    for (int n = 0; n < 600; n++) begin
      if (!retry) begin
        ins = rand_instr();
        pc  = pc + 64'd4;
      end
      fl = ($urandom_range(0, 9) == 0);
      drive(ins, {$urandom, $urandom} ^ pc, $urandom_range(0, 1) == 1, pick_reg(),
            {$urandom, $urandom}, fl, $urandom_range(0, 199) == 0, s);
      retry = s && !fl;
    end

    repeat (3) @(posedge CLK);
    #2;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage ARMv8 (LEGv8 subset) pipeline; consumes id_instr / id_nextseqpc from the IF/ID register.
- Contains the 32x64 register file, control decode, immediate extension, load-use hazard detection and the ID/EX pipeline register.
- Drives the EX stage and returns a stall to IF.

Parameters:
- NREGS, 32, architectural register count; X31 is XZR.
- XLEN, 64, datapath width.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- resetl  input  1  synchronous active-low reset.
- id_instr  input  32  instruction from IF/ID.
- id_nextseqpc  input  64  PC+4 from IF/ID.
- wb_regwrite  input  1  writeback enable.
- wb_rd  input  5  writeback destination.
- wb_data  input  64  writeback value.
- flush  input  1  taken-branch squash from EX/MEM.
- stall  output  1  combinational; freezes PC and IF/ID.
- ex_pc  output  64  registered id_nextseqpc - 4.
- ex_rdata1, ex_rdata2  output  64 each  registered operands.
- ex_imm  output  64  registered extended immediate.
- ex_rd  output  5  registered Rt/Rd field.
- ex_aluop  output  4  registered ALU control.
- ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_uncondbranch  output  1 each  registered control bits.

Behaviour:
- Reset (resetl=0 at posedge): all ex_* outputs = 0; all 31 registers = 0. stall is 0 while ex_memread = 0.
- Decode uses id_instr[31:21], matched as:
  - LDUR: 11111000010
  - STUR: 11111000000
  - ADD: 10001011000
  - SUB: 11001011000
  - AND: 10001010000
  - ORR: 10101010000
  - CBZ: [31:24] = 10110100
  - B: [31:26] = 000101
  - MOVZ: [31:23] = 110100101
  - Any other encoding: all control bits 0 (NOP).
- Register read ports:
  - rs1 = [9:5].
  - rs2 = [4:0] (Rt) for STUR/CBZ, otherwise [20:16].
- Register file semantics:
  - Reads of register 31 return 0.
  - Writes to 31 are ignored.
  - Write-through bypass: if wb_regwrite, wb_rd != 31 and wb_rd equals a read index, that port returns wb_data in the same cycle.
  - The register write itself occurs at posedge.
- Immediates:
  - D-type: sign-extend [20:12].
  - B: sign-extend [25:0], shifted left 2.
  - CB: sign-extend [23:5], shifted left 2.
  - MOVZ: zero-extend [20:5], shifted left 16*[22:21].
  - ALU ops: 0.
- ALUOp encoding: ADD/LDUR/STUR = 0010, SUB = 0110, AND = 0000, ORR = 0001, CBZ = 0111 (pass B), MOVZ = 0111.
- Load-use hazard:
  - stall = ex_memread & (ex_rd != 31) & ((ex_rd == rs1 & rs1 used) | (ex_rd == rs2 & rs2 used)).
  - rs1 is unused for B and MOVZ; rs2 is used only for R-type, STUR and CBZ.
- ID/EX update at each posedge, in priority order:
  1. Reset: all outputs 0.
  2. flush or stall: bubble; all control bits 0, data fields don't-care, held at 0.
  3. Otherwise: capture decoded values.
- flush and stall together: bubble. stall is still asserted to IF; IF/ID flush has priority there.
- Latency: 1 cycle from IF/ID to ID/EX outputs.
- A writeback to the stalled source register during a stall is picked up on the retry cycle via the bypass/register file.

Decomposition:
- Shared package holds:
  - opcode match constants (LDUR, STUR, ADD, SUB, AND, ORR, CBZ, B, MOVZ);
  - ALUOp codes;
  - the XZR index constant 31.
- One natural sub-module: regfile (2 read ports, 1 write port, synchronous reset, XZR and write-through bypass).
- Decode, immediate extension and hazard logic stay in id_stage.

Test Plan:
- Reset / X31: hold resetl=0 for 2 cycles, then write X31 = 0xDEAD via WB and read X31 with ADD X1,X31,X31 (0x8B1F03E1) -> after reset all ex_* = 0; ex_rdata1 = ex_rdata2 = 0, ex_regwrite = 1, ex_rd = 1, ex_aluop = 0010.
- Bypass: wb writes X2 = 0x1234 in the same cycle that SUB X3,X2,X2 (0xCB020043) is in ID -> next cycle ex_rdata1 = ex_rdata2 = 0x1234, ex_aluop = 0110.
- Load-use: LDUR X5,[X0,#-8] followed by ADD X6,X5,X1:
  - stall = 1 for exactly one cycle, ex_* control = 0 (bubble), and ex_imm of the LDUR = 0xFFFFFFFFFFFFFFF8;
  - the ADD issues the following cycle.
- No hazard on XZR or unused rs1: LDUR into X31 followed by ADD X1,X31,X2 -> stall = 0. LDUR X4 followed by MOVZ X4,#1,LSL#16 -> stall = 0, ex_imm = 0x10000.
- Branch immediates and flush:
  - B with imm26 = -1 -> ex_imm = 0xFFFFFFFFFFFFFFFC, ex_uncondbranch = 1.
  - CBZ imm19 = 3 -> ex_imm = 12, ex_branch = 1.
  - flush = 1 alongside a valid ADD -> all ex_* control bits 0 on the next cycle.
